// File: rtl/lcd_frame_streamer_pkg.sv
// Shared widths, command encodings and FSM states for the LCD frame streamer.
// Mirrors the lcd.vh directive values so the streamer can be built standalone.
package lcd_frame_streamer_pkg;

    localparam int LCD_DATA_BIT_WIDTH              = 8;
    localparam int LCD_ROW_COUNT_BIT_WIDTH         = 6;
    localparam int LCD_ADDR_Y_COUNT_BIT_WIDTH      = 7;
    localparam int LCD_ADDR_X_COUNT_BIT_WIDTH      = 3;
    localparam int LCD_DATA_ACTION_COUNT_BIT_WIDTH = 3;
    localparam int LCD_FB_ADDR_BIT_WIDTH           = 10;
    localparam int LCD_PAGE_COUNT                  = 8;
    localparam int LCD_COL_COUNT                   = 128;

    typedef enum logic [LCD_DATA_ACTION_COUNT_BIT_WIDTH-1:0] {
        LCD_DATA_ACTION_WRITE_DATA               = 3'd0,
        LCD_DATA_ACTION_WRITE_DISPLAY_START_LINE = 3'd1,
        LCD_DATA_ACTION_WRITE_ADDR_X             = 3'd2,
        LCD_DATA_ACTION_WRITE_ADDR_Y             = 3'd3,
        LCD_DATA_ACTION_DISPLAY_ON               = 3'd4,
        LCD_DATA_ACTION_DISPLAY_OFF              = 3'd5
    } lcd_action_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_LATCH   = 3'd2,
        ST_PRESENT = 3'd3,
        ST_ACK     = 3'd4,
        ST_DRAIN   = 3'd5,
        ST_SCROLL  = 3'd6,
        ST_DONE    = 3'd7
    } state_e;

    // Frame-buffer address is page-major: {page[2:0], col[6:0]}.
    function automatic logic [LCD_FB_ADDR_BIT_WIDTH-1:0] fb_addr(
        input logic [LCD_ADDR_X_COUNT_BIT_WIDTH-1:0] page,
        input logic [LCD_ADDR_Y_COUNT_BIT_WIDTH-1:0] col
    );
        return {page, col};
    endfunction

endpackage

// File: rtl/lcd_frame_streamer_if.sv
// Frame-buffer read port plus encoder command handshake, grouped as one bundle.
// master = streamer side, slave = encoder / frame-buffer RAM side.
interface lcd_frame_streamer_if
    import lcd_frame_streamer_pkg::*;
();
    logic [LCD_FB_ADDR_BIT_WIDTH-1:0]      fb_rd_addr;
    logic                                  fb_rd_en;
    logic [LCD_DATA_BIT_WIDTH-1:0]         fb_rd_data;
    logic [LCD_DATA_BIT_WIDTH-1:0]         data_write;
    logic [LCD_ROW_COUNT_BIT_WIDTH-1:0]    start_line_write;
    logic [LCD_ADDR_Y_COUNT_BIT_WIDTH-1:0] addr_y;
    logic [LCD_ADDR_X_COUNT_BIT_WIDTH-1:0] addr_x;
    lcd_action_e                           data_action;
    logic                                  data_busy;
    logic                                  instr_busy;

    modport master (
        output fb_rd_addr, fb_rd_en,
        output data_write, start_line_write, addr_y, addr_x, data_action, data_busy,
        input  fb_rd_data, instr_busy
    );

    modport slave (
        input  fb_rd_addr, fb_rd_en,
        input  data_write, start_line_write, addr_y, addr_x, data_action, data_busy,
        output fb_rd_data, instr_busy
    );
endinterface

// File: rtl/lcd_busy_sync.sv
// Multi-flop synchroniser bringing the encoder's instr_busy into clk_ctrl.
// Resets to 0 so the streamer sees an idle encoder out of reset.
module lcd_busy_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/lcd_frame_streamer.sv
// Walks the 1024-byte page-major frame buffer and hands each byte to the LCD
// encoder as a WRITE_DATA command, optionally followed by a scroll command.
module lcd_frame_streamer
    import lcd_frame_streamer_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int SCROLL_STEP = 1
) (
    input  logic                        clk_ctrl,
    input  logic                        reset_n,
    input  logic                        frame_start,
    input  logic                        scroll_en,
    output logic                        busy,
    output logic                        frame_done,
    lcd_frame_streamer_if.master        bus
);

    localparam logic [LCD_ROW_COUNT_BIT_WIDTH-1:0] STEP = LCD_ROW_COUNT_BIT_WIDTH'(SCROLL_STEP);

    state_e                           state;
    logic [LCD_FB_ADDR_BIT_WIDTH-1:0] pos;
    logic [LCD_FB_ADDR_BIT_WIDTH-1:0] next_pos;
    logic                             last_byte;
    logic                             scroll_lat;
    logic                             scroll_cmd;
    logic                             ib;

    lcd_busy_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_busy_sync (
        .clk   (clk_ctrl),
        .rst_n (reset_n),
        .d     (bus.instr_busy),
        .q     (ib)
    );

    // pos is {page, col}; one linear counter gives the col wrap -> page step for free.
    assign next_pos  = pos + LCD_FB_ADDR_BIT_WIDTH'(1);
    assign last_byte = (pos == '1);

    always_ff @(posedge clk_ctrl or negedge reset_n) begin
        if (!reset_n) begin
            state                <= ST_IDLE;
            busy                 <= 1'b0;
            frame_done           <= 1'b0;
            pos                  <= '0;
            scroll_lat           <= 1'b0;
            scroll_cmd           <= 1'b0;
            bus.fb_rd_en         <= 1'b0;
            bus.fb_rd_addr       <= '0;
            bus.data_write       <= '0;
            bus.start_line_write <= '0;
            bus.addr_y           <= '0;
            bus.addr_x           <= '0;
            bus.data_action      <= LCD_DATA_ACTION_WRITE_DATA;
            bus.data_busy        <= 1'b1;
        end else begin
            frame_done   <= 1'b0;
            bus.fb_rd_en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (frame_start) begin
                        busy           <= 1'b1;
                        scroll_lat     <= scroll_en;
                        scroll_cmd     <= 1'b0;
                        pos            <= '0;
                        bus.fb_rd_en   <= 1'b1;
                        bus.fb_rd_addr <= fb_addr('0, '0);
                        state          <= ST_FETCH;
                    end
                end
                // Read strobe is high during FETCH; RAM data is valid in LATCH.
                ST_FETCH: state <= ST_LATCH;
                ST_LATCH: begin
                    bus.data_write  <= bus.fb_rd_data;
                    bus.addr_x      <= pos[LCD_FB_ADDR_BIT_WIDTH-1 -: LCD_ADDR_X_COUNT_BIT_WIDTH];
                    bus.addr_y      <= pos[LCD_ADDR_Y_COUNT_BIT_WIDTH-1:0];
                    bus.data_action <= LCD_DATA_ACTION_WRITE_DATA;
                    state           <= ST_PRESENT;
                end
                ST_PRESENT: begin
                    if (!ib) begin
                        bus.data_busy <= 1'b0;
                        state         <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    if (ib) begin
                        bus.data_busy <= 1'b1;
                        state         <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!ib) begin
                        if (scroll_cmd) begin
                            state <= ST_DONE;
                        end else if (last_byte) begin
                            state <= scroll_lat ? ST_SCROLL : ST_DONE;
                        end else begin
                            pos            <= next_pos;
                            bus.fb_rd_en   <= 1'b1;
                            bus.fb_rd_addr <= next_pos;
                            state          <= ST_FETCH;
                        end
                    end
                end
                ST_SCROLL: begin
                    bus.start_line_write <= bus.start_line_write - STEP;
                    bus.data_action      <= LCD_DATA_ACTION_WRITE_DISPLAY_START_LINE;
                    bus.addr_y           <= '0;
                    bus.addr_x           <= '0;
                    bus.data_write       <= '0;
                    scroll_cmd           <= 1'b1;
                    state                <= ST_PRESENT;
                end
                ST_DONE: begin
                    frame_done <= 1'b1;
                    busy       <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/lcd_frame_streamer.md
Name: lcd_frame_streamer

Overview:
- Upstream command source for lcd_encoder.
- Scans a 128x64 monochrome frame buffer (1024 bytes, page-major) and issues one `LCD_DATA_ACTION_WRITE_DATA` command per byte over the data_busy/instr_busy handshake.
- After each frame it can issue one `LCD_DATA_ACTION_WRITE_DISPLAY_START_LINE` command for vertical scrolling.
- Runs in the controller clock domain; the frame buffer is an external synchronous-read RAM.

Parameters:
- SYNC_STAGES, 2, flops in the instr_busy synchroniser (encoder runs on clk_lcd); legal range 1..3.
- SCROLL_STEP, 1, start-line decrement per frame when scrolling (mod 64).

Ports:
- clk_ctrl  in  1  controller clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-cycle pulse requesting one full frame.
- scroll_en  in  1  sampled at frame_start; 1 appends a start-line command after the frame.
- fb_rd_addr  out  10  frame-buffer byte address {page[2:0], col[6:0]}.
- fb_rd_en  out  1  read strobe; data valid on fb_rd_data one cycle later.
- fb_rd_data  in  `LCD_DATA_BIT_WIDTH  frame-buffer read data.
- data_write  out  `LCD_DATA_BIT_WIDTH  byte to the encoder.
- start_line_write  out  `LCD_ROW_COUNT_BIT_WIDTH  display start line.
- addr_y  out  `LCD_ADDR_Y_COUNT_BIT_WIDTH  column 0..127; bit 6 selects the chip.
- addr_x  out  `LCD_ADDR_X_COUNT_BIT_WIDTH  page 0..7.
- data_action  out  `LCD_DATA_ACTION_COUNT_BIT_WIDTH  command type.
- data_busy  out  1  0 = command presented and valid; 1 = nothing pending.
- instr_busy  in  1  from the encoder, asynchronous to clk_ctrl.
- busy  out  1  high from accepted frame_start until frame_done.
- frame_done  out  1  one-cycle pulse when the last command of the frame completes.

Behaviour:
- Reset values:
  - data_busy=1, busy=0, frame_done=0, fb_rd_en=0, fb_rd_addr=0.
  - data_write=0, start_line_write=0, addr_y=0, addr_x=0.
  - data_action=`LCD_DATA_ACTION_WRITE_DATA; FSM in IDLE.
  - Reset mid-frame aborts immediately to these values; no partial command is held.
- instr_busy passes through SYNC_STAGES flops; "ib" below denotes the synchronised value.
- FSM states: IDLE, FETCH, LATCH, PRESENT, ACK, DRAIN, SCROLL, DONE.
  - IDLE: frame_start=1 -> set busy=1, latch scroll_en, reset page/col to 0, go to FETCH. frame_start is ignored in every other state.
  - FETCH: fb_rd_en=1, fb_rd_addr={page,col} -> LATCH.
  - LATCH: data_write<=fb_rd_data, addr_x<=page, addr_y<=col, data_action<=WRITE_DATA -> PRESENT.
  - PRESENT: wait for ib=0, then drive data_busy<=0 -> ACK.
  - ACK: hold all command outputs stable; on ib=1 set data_busy<=1 -> DRAIN.
  - DRAIN: on ib=0:
    - if col=127 and page=7: -> SCROLL if scroll latched, else DONE.
    - otherwise increment col; on wrap 127->0 increment page; -> FETCH.
  - SCROLL: start_line_write<=start_line_write-SCROLL_STEP (6-bit wrap, 0-1=63), data_action<=WRITE_DISPLAY_START_LINE, addr_y<=0, addr_x<=0, data_write<=0, then perform PRESENT/ACK/DRAIN once -> DONE.
  - DONE: frame_done=1 for one cycle, busy<=0 -> IDLE.
- Command outputs must not change while data_busy=0.
- Exactly 1024 data commands per frame, plus 1 start-line command if scrolling.
- start_line_write persists across frames; it is cleared only by reset.
- No timeout: a stuck-high ib stalls in DRAIN indefinitely.

Decomposition:
- Add to src/directive/lcd.vh:
  - LCD_FB_ADDR_BIT_WIDTH=10, LCD_PAGE_COUNT=8, LCD_COL_COUNT=128.
  - FSM state encodings (3 bits).
- Reuse the existing LCD_DATA_ACTION_* macros.
- One sub-module: lcd_busy_sync (SYNC_STAGES-deep bit synchroniser with async active-low reset to 0).

Test Plan:
- Reset held, then released with no frame_start -> data_busy=1, busy=0, fb_rd_en=0; no command issued over 100 cycles.
- frame_start, scroll_en=0, fb byte i = i[7:0], encoder model busy for 4 clk_lcd per command -> 1024 commands, each with data_write=addr[7:0], addr_x=addr[9:7], addr_y=addr[6:0]; frame_done after the last; start_line_write stays 0.
- Three consecutive scrolled frames from reset -> start-line commands carry 63, 62, 61; data_action=WRITE_DISPLAY_START_LINE with addr_y=0, addr_x=0.
- Encoder holds instr_busy=1 for 50 cycles mid-command -> data_busy stays 1 and no new command or fb read occurs until release; the next command then appears.
- frame_start pulsed while busy -> ignored; exactly one frame_done.
- reset_n pulsed low at command 300 -> all outputs return to reset values asynchronously; a new frame_start restarts at page 0, col 0.
